// File: rtl/tns_tx_arbiter.sv
// tns_tx_arbiter
//   Round-robin arbiter/sequencer sharing one TNS crosstalk-avoidance encoder
//   between NREQ requesters. Grants bounded bursts, holds the encoder word
//   stable whenever nothing is transferred, and inserts GUARD hold cycles when
//   ownership moves to a different requester.
// Ports
//   clock       system clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   per-requester word offer
//   req_data    requester i word at [i*DW +: DW]
//   req_ready   one-hot accept of the current owner (GRANT only)
//   enc_datain  registered word driving the encoder datain
//   enc_load    one-cycle pulse when enc_datain carries a new word
//   enc_src     owner index of the word on enc_datain
//   busy        high in GRANT or GUARD
module tns_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 15,
  parameter int MAX_BURST = 8,
  parameter int GUARD     = 1
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [DW-1:0]            enc_datain,
  output logic                     enc_load,
  output logic [$clog2(NREQ)-1:0]  enc_src,
  output logic                     busy
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GUARD} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   cur, cur_n, ptr, ptr_n;
  logic [7:0]      bcnt, bcnt_n;
  logic [3:0]      gcnt, gcnt_n;
  logic            sent;
  logic            xfer;
  logic            any_req;
  logic [IW-1:0]   win_idle, win_end, ptr_end;

  // Index following p, wrapping at NREQ (NREQ need not be a power of two).
  function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] p);
    return (p == IW'(NREQ - 1)) ? '0 : p + IW'(1);
  endfunction

  // First set bit of v scanning upward from p with wrap-around. Offsets are
  // visited from the far end so the nearest requester overwrites the result.
  function automatic logic [IW-1:0] pick(input logic [NREQ-1:0] v,
                                         input logic [IW-1:0]   p);
    logic [IW-1:0] res;
    int            s;
    res = p;
    for (int k = NREQ - 1; k >= 0; k--) begin
      s = int'(p) + k;
      if (s >= NREQ) s = s - NREQ;
      if (v[s]) res = IW'(s);
    end
    return res;
  endfunction

  assign any_req  = |req_valid;
  assign ptr_end  = inc_mod(cur);
  assign win_idle = pick(req_valid, ptr);
  // Burst-end re-arbitration uses the already-rotated pointer.
  assign win_end  = pick(req_valid, ptr_end);

  always_comb begin
    state_n = state;
    cur_n   = cur;
    ptr_n   = ptr;
    bcnt_n  = bcnt;
    gcnt_n  = gcnt;
    xfer    = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          cur_n  = win_idle;
          bcnt_n = '0;
          // No guard needed when the owner would not change on the wire.
          if (win_idle == enc_src || GUARD == 0 || !sent) begin
            state_n = S_GRANT;
          end else begin
            state_n = S_GUARD;
            gcnt_n  = 4'(GUARD - 1);
          end
        end
      end
      S_GRANT: begin
        xfer = req_valid[cur];
        if (xfer) bcnt_n = bcnt + 8'd1;
        if (!xfer || bcnt == 8'(MAX_BURST - 1)) begin
          ptr_n = ptr_end;
          if (any_req && win_end != cur && GUARD > 0) begin
            state_n = S_GUARD;
            cur_n   = win_end;
            bcnt_n  = '0;
            gcnt_n  = 4'(GUARD - 1);
          end else if (any_req) begin
            cur_n  = win_end;
            bcnt_n = '0;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_GUARD: begin
        if (gcnt == '0) state_n = S_GRANT;
        else            gcnt_n  = gcnt - 4'd1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state == S_GRANT) req_ready[cur] = 1'b1;
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cur        <= '0;
      ptr        <= '0;
      bcnt       <= '0;
      gcnt       <= '0;
      sent       <= 1'b0;
      enc_datain <= '0;
      enc_src    <= '0;
      enc_load   <= 1'b0;
    end else begin
      state    <= state_n;
      cur      <= cur_n;
      ptr      <= ptr_n;
      bcnt     <= bcnt_n;
      gcnt     <= gcnt_n;
      enc_load <= xfer;
      // Encoder word and source only move on a transfer; otherwise held.
      if (xfer) begin
        enc_datain <= req_data[int'(cur)*DW +: DW];
        enc_src    <= cur;
        sent       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tns_tx_arbiter.sv
// Testbench for tns_tx_arbiter: table of multi-requester scenarios with a
// scoreboard of expected encoder words, plus hand-written reset, guard and
// GUARD=0 sequences.
module tb_tns_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 15;
  localparam int MB   = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                 rst_n;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [NREQ*DW-1:0]   req_data;
  logic [DW-1:0]        enc_datain;
  logic                 enc_load;
  logic [1:0]           enc_src;
  logic                 busy;

  logic [NREQ-1:0]      g_valid, g_ready;
  logic [NREQ*DW-1:0]   g_data;
  logic [DW-1:0]        g_datain;
  logic                 g_load;
  logic [1:0]           g_src;
  logic                 g_busy;

  tns_tx_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MB), .GUARD(1)) u_dut (
    .clock(clock), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .enc_datain(enc_datain), .enc_load(enc_load),
    .enc_src(enc_src), .busy(busy));

  tns_tx_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(1), .GUARD(0)) u_g0 (
    .clock(clock), .rst_n(rst_n), .req_valid(g_valid), .req_data(g_data),
    .req_ready(g_ready), .enc_datain(g_datain), .enc_load(g_load),
    .enc_src(g_src), .busy(g_busy));

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    src;
  } exp_t;

  typedef struct packed {
    logic [NREQ-1:0][7:0] cnt;
    logic [15:0]          span;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   first_load = -1;
  int   last_load = -1;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] word(input int i, input int k);
    return DW'(i * 4096 + k * 8 + 3);
  endfunction

  function automatic vec_t mk(input int c0, input int c1, input int c2, input int c3,
                              input int span);
    vec_t v;
    v.cnt[0] = 8'(c0);
    v.cnt[1] = 8'(c1);
    v.cnt[2] = 8'(c2);
    v.cnt[3] = 8'(c3);
    v.span   = 16'(span);
    return v;
  endfunction

  // Expected encoder order: cyclic scan from requester 0, each pending
  // requester taking up to MB words per visit.
  task automatic push_model(input vec_t v);
    int rem[NREQ];
    int took[NREQ];
    int n;
    bit more;
    for (int i = 0; i < NREQ; i++) begin
      rem[i]  = int'(v.cnt[i]);
      took[i] = 0;
    end
    do begin
      more = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (rem[i] > 0) begin
          n = (rem[i] > MB) ? MB : rem[i];
          for (int j = 0; j < n; j++) exp_q.push_back({word(i, took[i] + j), 2'(i)});
          took[i] += n;
          rem[i]  -= n;
        end
      end
      for (int i = 0; i < NREQ; i++) if (rem[i] > 0) more = 1'b1;
    end while (more);
  endtask

  // Requester model: offers cnt[i] words each, advancing on observed handshakes.
  task automatic drive(input logic [NREQ-1:0][7:0] cnt, input int base,
                       input int stop_after, input int budget);
    int sent[NREQ];
    logic [NREQ-1:0] hs;
    int nhs;
    bit done;
    hs = '0;
    nhs = 0;
    done = 1'b0;
    for (int i = 0; i < NREQ; i++) sent[i] = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clock);
      for (int i = 0; i < NREQ; i++) if (hs[i]) begin sent[i]++; nhs++; end
      if (stop_after >= 0 && nhs >= stop_after) begin
        done = 1'b1;
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          req_valid[i] = (sent[i] < int'(cnt[i]));
          req_data[i*DW +: DW] = word(i, base + sent[i]);
        end
        hs = req_valid & req_ready;
        if (req_valid == '0 && !busy) done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout: got %0d handshakes, required completion within %0d cycles",
               nhs, budget);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst_n = 1'b0;
    req_valid = '0;
    g_valid = '0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
  endtask

  // Output monitor: pops the scoreboard on every load, checks holds otherwise.
  initial begin
    logic [DW-1:0] last_data;
    logic [1:0]    last_src;
    exp_t          e;
    last_data = '0;
    last_src  = '0;
    forever begin
      @(negedge clock);
      if (!rst_n) begin
        last_data = '0;
        last_src  = '0;
      end else begin
        chk("ready_onehot", {31'd0, ($countones(req_ready) <= 1) && (busy || req_ready == '0)}, 1);
        if (enc_load) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_load: got data %0h src %0d, required no load",
                     enc_datain, enc_src);
          end else begin
            e = exp_q.pop_front();
            chk("load_data", enc_datain, e.data);
            chk("load_src", enc_src, e.src);
          end
          if (first_load < 0) first_load = cyc;
          last_load = cyc;
        end else begin
          chk("hold_data", enc_datain, last_data);
          chk("hold_src", enc_src, last_src);
        end
        last_data = enc_datain;
        last_src  = enc_src;
      end
    end
  end

  initial begin
    vec_t v;
    vecs[0] = mk(0, 0, 20, 0, 19);
    vecs[1] = mk(16, 16, 16, 16, 70);
    vecs[2] = mk(0, 3, 0, 5, 9);
    vecs[3] = mk(10, 0, 4, 0, 16);
    vecs[4] = mk(1, 1, 1, 1, 9);

    // Reset with every request high.
    rst_n = 1'b0;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = word(i, 0);
    g_valid = '0;
    g_data = '0;
    repeat (3) @(negedge clock);
    chk("rst_ready", req_ready, 0);
    chk("rst_datain", enc_datain, 0);
    chk("rst_load", enc_load, 0);
    chk("rst_src", enc_src, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clock);
    chk("first_grant", req_ready, 4'b0001);
    chk("first_busy", busy, 1);
    #2 rst_n = 1'b0;
    req_valid = '0;
    #1 chk("rst_async_ready", req_ready, 0);
    @(negedge clock);
    rst_n = 1'b1;

    // Table-driven scenarios.
    for (int n = 0; n < 5; n++) begin
      do_reset();
      push_model(vecs[n]);
      first_load = -1;
      last_load = -1;
      drive(vecs[n].cnt, 0, -1, 400);
      chk("vec_drain", exp_q.size(), 0);
      chk("vec_span", last_load - first_load, 32'(vecs[n].span));
    end

    // Reset during word 5 of a burst, then restart without duplication.
    do_reset();
    for (int k = 0; k < 4; k++) exp_q.push_back({word(0, k), 2'd0});
    v = mk(20, 0, 0, 0, 0);
    drive(v.cnt, 0, 4, 100);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_load", enc_load, 0);
    chk("midrst_datain", enc_datain, 0);
    chk("midrst_src", enc_src, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", req_ready, 0);
    chk("midrst_queue", exp_q.size(), 0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    for (int k = 4; k < 7; k++) exp_q.push_back({word(0, k), 2'd0});
    v = mk(3, 0, 0, 0, 0);
    drive(v.cnt, 4, -1, 100);
    chk("restart_drain", exp_q.size(), 0);

    // From IDLE with a different last source: guard before the grant.
    exp_q.push_back({word(3, 0), 2'd3});
    @(negedge clock);
    req_valid = 4'b1000;
    req_data[3*DW +: DW] = word(3, 0);
    @(negedge clock);
    chk("idle_guard_ready", req_ready, 0);
    chk("idle_guard_busy", busy, 1);
    @(negedge clock);
    chk("idle_guard_grant", req_ready, 4'b1000);
    @(negedge clock);
    req_valid = '0;
    @(negedge clock);
    // Same source again from IDLE: no guard.
    exp_q.push_back({word(3, 1), 2'd3});
    req_valid = 4'b1000;
    req_data[3*DW +: DW] = word(3, 1);
    @(negedge clock);
    chk("same_src_grant", req_ready, 4'b1000);
    @(negedge clock);
    req_valid = '0;
    repeat (2) @(negedge clock);
    chk("same_src_drain", exp_q.size(), 0);

    // GUARD=0, MAX_BURST=1: back-to-back loads from different sources.
    do_reset();
    @(negedge clock);
    g_valid = 4'b0011;
    g_data[0 +: DW] = 15'h1234;
    g_data[DW +: DW] = 15'h0ABC;
    @(negedge clock);
    chk("g0_grant0", g_ready, 4'b0001);
    @(negedge clock);
    chk("g0_load1", g_load, 1);
    chk("g0_data1", g_datain, 15'h1234);
    chk("g0_src1", g_src, 0);
    chk("g0_grant1", g_ready, 4'b0010);
    g_valid = 4'b0010;
    @(negedge clock);
    chk("g0_load2", g_load, 1);
    chk("g0_data2", g_datain, 15'h0ABC);
    chk("g0_src2", g_src, 1);
    g_valid = '0;
    @(negedge clock);
    chk("g0_load_end", g_load, 0);
    chk("g0_hold", g_datain, 15'h0ABC);
    chk("g0_idle", g_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
